bus_arbiter2: RTL and testbench
===============================

Name: bus_arbiter2

Overview:
- Two-master, one-slave arbiter for the CPU memory bus (addr/wdata/wmask/rdata/wen/ren/done handshake).
- Shares the single memory/peripheral slave between master 0 (CPU core) and master 1 (debug loader or DMA).
- Grants one whole transaction at a time, routes the handshake, and re-arbitrates only after a release cycle.
- Sits between the cpu bus port and the memory/peripheral decoder.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on simultaneous requests; 0 = fixed priority, m0 always wins.
- TIMEOUT_CYCLES, 256: cycles a granted transaction may wait for s_done; used only with the optional feature.
- TIMEOUT_RDATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m0_addr, m1_addr  in  32  master byte address
- m0_wdata, m1_wdata  in  32  master write data
- m0_wmask, m1_wmask  in  4  master byte write mask
- m0_wen, m1_wen  in  1  master write request (level)
- m0_ren, m1_ren  in  1  master read request (level)
- m0_rdata, m1_rdata  out  32  read data to master
- m0_done, m1_done  out  1  one-cycle completion pulse to master
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wmask  out  4  slave write mask
- s_wen, s_ren  out  1  slave strobes
- s_rdata  in  32  slave read data
- s_done  in  1  slave completion pulse
- grant  out  2  one-hot current owner; 00 when idle
- err  out  1  sticky timeout flag

Behaviour:
- Request definition: mX_req = mX_wen | mX_ren. A master holds its request and payload stable until it sees mX_done, then drops the request within one cycle.
- States: IDLE, GRANT0, GRANT1, RELEASE. State is registered.
- IDLE:
  - Only m0_req → GRANT0. Only m1_req → GRANT1. Neither → stay in IDLE.
  - Both requesting with ROUND_ROBIN=1: grant the master that is not last_grant.
  - Both requesting with ROUND_ROBIN=0: grant m0.
  - On any grant, last_grant is updated to the granted master.
- GRANTx:
  - s_* outputs are combinationally muxed from master x.
  - mX_done = s_done. The other master's done = 0.
  - On s_done → RELEASE.
  - If master x drops its request before s_done (protocol violation): deassert s strobes and → RELEASE without a done pulse.
- RELEASE: one cycle with s_wen = s_ren = 0, grant = 00, then → IDLE. This prevents a master from being re-granted on its stale request in the cycle it sees done.
- s_addr, s_wdata, s_wmask are 0 when not granted.
- s_rdata is routed to both mX_rdata at all times, except the timeout case below.
- Latency:
  - Request sampled in IDLE at cycle N; slave strobe is asserted at N+1.
  - Minimum per transaction is 3 cycles for a 1-cycle slave: grant, done, release.
  - Back-to-back requests from the same master are separated by at least one idle cycle.
- Reset values: state = IDLE, last_grant = m1 (so m0 wins the first tie), grant = 00, all done and strobe outputs 0, err = 0, timeout counter 0.
- Reset mid-transaction: slave strobes drop immediately (asynchronous). No done pulse is issued and the transaction is abandoned.
- Simultaneous events: a new request arriving in the same cycle as s_done is not considered until IDLE.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to GRANTx and increments each GRANTx cycle without s_done.
  - When it reaches TIMEOUT_CYCLES, the arbiter pulses mX_done for one cycle with mX_rdata = TIMEOUT_RDATA, deasserts the slave strobes, sets err (sticky until rst), and → RELEASE.
  - s_done in the same cycle as the timeout wins: normal completion, err is not set.
- Disabled: no counter; the arbiter waits for s_done indefinitely; err is tied to 0.

Test Plan:
- Single master: m0_ren at addr 0x100, slave returns 0x12345678 with a 1-cycle delay → s_ren asserted at N+1, m0_done pulses once with m0_rdata = 0x12345678, grant sequence 01 → 00 (RELEASE) → 00 (IDLE).
- Simultaneous: m0_ren and m1_wen (addr 0x200, wdata 0xA5A5A5A5, wmask 4'b0011) held continuously, ROUND_ROBIN=1 → grants alternate 01, 10, 01; slave sees the exact m1 payload during 10; each master receives exactly one done per grant.
- Fixed priority: ROUND_ROBIN=0 with both masters requesting continuously → m1 is never granted while m0 keeps re-requesting after each done.
- Reset mid-grant: assert rst while GRANT1 is waiting on the slave → s_wen/s_ren = 0 in the same cycle, grant = 00, no m1_done; after release the next tie goes to m0.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never asserts s_done → m0_done pulses on the 8th waiting cycle, m0_rdata = 0xDEADBEEF, err = 1 and stays 1; a subsequent normal transaction completes correctly with err still 1.
- Protocol violation: m1 drops m1_ren before s_done → strobes drop, no m1_done, FSM passes through RELEASE to IDLE.

Source files
------------

// File: rtl/bus_arbiter2_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter2_if
// Bundles the two master-side request buses, the shared slave bus and the
// arbiter status for bus_arbiter2.
//
// Signals:
//   m0_* / m1_*  master request payload (addr, wdata, wmask, wen, ren) and
//                the per-master responses (rdata, done)
//   s_*          single shared slave bus (addr, wdata, wmask, wen, ren out of
//                the arbiter; rdata, done back from the slave)
//   grant        one-hot current owner, 00 when idle
//   err          sticky timeout flag
//
// Modports:
//   master  the two requesting masters (CPU core, debug loader / DMA)
//   slave   the memory / peripheral decoder
//   arb     the arbiter itself, sitting between the two
// ---------------------------------------------------------------------------
interface bus_arbiter2_if;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m0_wen;
    logic        m0_ren;
    logic [31:0] m0_rdata;
    logic        m0_done;

    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_wen;
    logic        m1_ren;
    logic [31:0] m1_rdata;
    logic        m1_done;

    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic        s_wen;
    logic        s_ren;
    logic [31:0] s_rdata;
    logic        s_done;

    logic [1:0]  grant;
    logic        err;

    modport master (
        output m0_addr, m0_wdata, m0_wmask, m0_wen, m0_ren,
        output m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren,
        input  m0_rdata, m0_done, m1_rdata, m1_done, grant, err
    );

    modport slave (
        input  s_addr, s_wdata, s_wmask, s_wen, s_ren,
        output s_rdata, s_done
    );

    modport arb (
        input  m0_addr, m0_wdata, m0_wmask, m0_wen, m0_ren,
        input  m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output s_addr, s_wdata, s_wmask, s_wen, s_ren,
        input  s_rdata, s_done,
        output grant, err
    );
endinterface

// File: rtl/bus_arbiter2.sv
// ---------------------------------------------------------------------------
// bus_arbiter2
// Two-master / one-slave arbiter for the CPU memory bus. Master 0 is the CPU
// core, master 1 the debug loader or DMA. One whole transaction is granted at
// a time; after every grant the arbiter spends one RELEASE cycle with the
// slave strobes low so a master cannot be re-granted on the stale request it
// still holds in the cycle it sees done.
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   bus_arbiter2_if.arb: master payloads in, master rdata/done out,
//         shared slave bus out, slave rdata/done in, grant and err out
//
// Parameters:
//   ROUND_ROBIN     1 = alternate on simultaneous requests, 0 = m0 always wins
//   TIMEOUT_CYCLES  grant cycles allowed without s_done (timeout build only)
//   TIMEOUT_RDATA   read data handed to the master on a timeout
//
// Optional feature (macro BUS_ARBITER_TIMEOUT_EN):
//   defined   - a granted transaction that sees no s_done for TIMEOUT_CYCLES
//               cycles is completed towards the master with TIMEOUT_RDATA,
//               the slave strobes are dropped and err is set (sticky)
//   undefined - the arbiter waits for s_done indefinitely, err is 0
// ---------------------------------------------------------------------------
module bus_arbiter2 #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input logic         clk,
    input logic         rst,
    bus_arbiter2_if.arb bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT0  = 2'd1,
        S_GRANT1  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_arbiter2: TIMEOUT_CYCLES must be at least 1");
    end

    state_t r_state;
    state_t w_next;
    logic   r_last;       // last granted master: 0 = m0, 1 = m1
    logic   w_req0;
    logic   w_req1;
    logic   w_granted;
    logic   w_owner_req;  // request level of the master currently granted
    logic   w_expired;    // wait budget used up in this grant cycle
    logic   w_timeout;    // expired, still requested and no s_done to save it

    assign w_req0      = bus.m0_wen | bus.m0_ren;
    assign w_req1      = bus.m1_wen | bus.m1_ren;
    assign w_granted   = (r_state == S_GRANT0) || (r_state == S_GRANT1);
    assign w_owner_req = (r_state == S_GRANT1) ? w_req1 : w_req0;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // The counter holds the number of grant cycles already spent waiting, so
    // the cycle in which it would reach TIMEOUT_CYCLES is the timeout cycle.
    // w_expired deliberately ignores s_done: it gates the slave strobes, and
    // keeping s_done out of that path avoids a combinational loop through a
    // slave that answers in the same cycle it sees a strobe.
    assign w_expired = w_granted && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = w_expired && w_owner_req && !bus.s_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_granted) begin
            r_cnt <= '0;
        end else if (!bus.s_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_expired = 1'b0;
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // State register; last_grant resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (w_next == S_GRANT0) begin
                    r_last <= 1'b0;
                end else if (w_next == S_GRANT1) begin
                    r_last <= 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                // m0 takes it when alone, under fixed priority, or when m1
                // was the last owner
                if (w_req0 && (!w_req1 || !ROUND_ROBIN || r_last)) begin
                    w_next = S_GRANT0;
                end else if (w_req1) begin
                    w_next = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                // A dropped request is a protocol violation: abandon quietly
                if (bus.s_done || !w_owner_req || w_timeout) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.grant    = 2'b00;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        bus.s_wmask  = '0;
        bus.s_wen    = 1'b0;
        bus.s_ren    = 1'b0;
        bus.m0_done  = 1'b0;
        bus.m1_done  = 1'b0;
        bus.m0_rdata = bus.s_rdata;
        bus.m1_rdata = bus.s_rdata;
        unique case (r_state)
            S_GRANT0: begin
                bus.grant   = 2'b01;
                bus.s_addr  = bus.m0_addr;
                bus.s_wdata = bus.m0_wdata;
                bus.s_wmask = bus.m0_wmask;
                bus.s_wen   = bus.m0_wen & ~w_expired;
                bus.s_ren   = bus.m0_ren & ~w_expired;
                bus.m0_done = bus.s_done | w_timeout;
                if (w_timeout) begin
                    bus.m0_rdata = TIMEOUT_RDATA;
                end
            end
            S_GRANT1: begin
                bus.grant   = 2'b10;
                bus.s_addr  = bus.m1_addr;
                bus.s_wdata = bus.m1_wdata;
                bus.s_wmask = bus.m1_wmask;
                bus.s_wen   = bus.m1_wen & ~w_expired;
                bus.s_ren   = bus.m1_ren & ~w_expired;
                bus.m1_done = bus.s_done | w_timeout;
                if (w_timeout) begin
                    bus.m1_rdata = TIMEOUT_RDATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
`timescale 1ns/1ps
module tb_bus_arbiter2;
    localparam int TO = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter2_if bus ();
    bus_arbiter2_if fbus ();

    bus_arbiter2 #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEADBEEF))
        dut (.clk(clk), .rst(rst), .bus(bus));
    bus_arbiter2 #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEADBEEF))
        dut_fp (.clk(clk), .rst(rst), .bus(fbus));

    int checks = 0;
    int failures = 0;

    // Bench-owned master payloads
    logic        p_wen[2];
    logic        p_ren[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_wmask[2];

    always_comb begin
        bus.m0_wen = p_wen[0];  bus.m0_ren = p_ren[0];  bus.m0_addr = p_addr[0];
        bus.m0_wdata = p_wdata[0];  bus.m0_wmask = p_wmask[0];
        bus.m1_wen = p_wen[1];  bus.m1_ren = p_ren[1];  bus.m1_addr = p_addr[1];
        bus.m1_wdata = p_wdata[1];  bus.m1_wmask = p_wmask[1];
    end

    // Fixed-priority instance: both masters request continuously, 1-cycle slave
    logic fp_on = 1'b0;
    always_comb begin
        fbus.m0_ren = fp_on;  fbus.m0_wen = 1'b0;  fbus.m0_addr = 32'h100;
        fbus.m0_wdata = 32'h0;  fbus.m0_wmask = 4'h0;
        fbus.m1_wen = fp_on;  fbus.m1_ren = 1'b0;  fbus.m1_addr = 32'h200;
        fbus.m1_wdata = 32'hA5A5A5A5;  fbus.m1_wmask = 4'b0011;
        fbus.s_rdata = 32'h0;
    end
    assign fbus.s_done = fbus.s_ren | fbus.s_wen;

    // Slave model
    int          sl_mode = 0;   // 0 = responds, 1 = never responds
    int          sl_lat = -1;   // <0 random 0..3, else fixed wait cycles
    int          sl_wait = 0;
    bit          sl_fix_en = 1'b0;
    logic [31:0] sl_fix = 32'h0;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    initial begin
        bus.s_done = 1'b0;
        bus.s_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            bus.s_done = 1'b0;
            bus.s_rdata = $urandom;
            if (!rst && (bus.s_wen || bus.s_ren) && sl_mode == 0) begin
                if (sl_wait == 0) begin
                    bus.s_done = 1'b1;
                    bus.s_rdata = sl_fix_en ? sl_fix : slv_data(bus.s_addr);
                    sl_wait = (sl_lat < 0) ? int'($urandom_range(0, 3)) : sl_lat;
                end else begin
                    sl_wait--;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: bit 32 set means rdata must be compared
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    task automatic sb_pop(input int x, input logic [31:0] rd);
        logic [32:0] e;
        if ((x == 0 && exp_q0.size() == 0) || (x == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL sb_m%0d_done: got unexpected done, expected no outstanding txn at %0t", x, $time);
            return;
        end
        if (x == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        if (e[32]) chk((x == 0) ? "m0_rdata" : "m1_rdata", rd, e[31:0]);
    endtask

    // Reference model: who owns the slave, whether a release cycle is due,
    // who won last, how long the owner has waited
    int mo_owner = 0;   // 0 none, 1 = m0, 2 = m1
    int mo_last  = 1;
    int mo_wait  = 0;
    bit mo_rel   = 1'b0;
    bit mo_err   = 1'b0;

    always @(negedge clk) begin
        logic r0, r1, oreq, gate, exp_to;
        logic [1:0] eg;
        int ox, pick;
        if (rst) begin
            mo_owner = 0; mo_rel = 1'b0; mo_last = 1; mo_wait = 0; mo_err = 1'b0;
        end
        r0 = p_wen[0] | p_ren[0];
        r1 = p_wen[1] | p_ren[1];
        ox = mo_owner - 1;
        oreq = (mo_owner == 1) ? r0 : (mo_owner == 2) ? r1 : 1'b0;
        gate = TO_EN && (mo_owner != 0) && (mo_wait == TO - 1);
        exp_to = gate && oreq && !bus.s_done;
        eg = (mo_owner == 1) ? 2'b01 : (mo_owner == 2) ? 2'b10 : 2'b00;

        chk("grant", bus.grant, eg);
        if (mo_owner != 0) begin
            chk("s_addr", bus.s_addr, p_addr[ox]);
            chk("s_wdata", bus.s_wdata, p_wdata[ox]);
            chk("s_wmask", bus.s_wmask, p_wmask[ox]);
            chk("s_wen", bus.s_wen, p_wen[ox] & !gate);
            chk("s_ren", bus.s_ren, p_ren[ox] & !gate);
        end else begin
            chk("s_addr_idle", bus.s_addr, 32'h0);
            chk("s_wdata_idle", bus.s_wdata, 32'h0);
            chk("s_wmask_idle", bus.s_wmask, 32'h0);
            chk("s_wen_idle", bus.s_wen, 32'h0);
            chk("s_ren_idle", bus.s_ren, 32'h0);
        end
        chk("m0_done", bus.m0_done, (mo_owner == 1) && (bus.s_done || exp_to));
        chk("m1_done", bus.m1_done, (mo_owner == 2) && (bus.s_done || exp_to));
        chk("err", bus.err, mo_err);
        if (bus.m0_done) sb_pop(0, bus.m0_rdata);
        if (bus.m1_done) sb_pop(1, bus.m1_rdata);

        if (!rst) begin
            if (mo_rel) begin
                mo_rel = 1'b0;
            end else if (mo_owner != 0) begin
                if (bus.s_done || !oreq || exp_to) begin
                    if (exp_to) mo_err = 1'b1;
                    mo_owner = 0;
                    mo_rel = 1'b1;
                end else begin
                    mo_wait++;
                end
            end else if (r0 || r1) begin
                if (r0 && r1) pick = (mo_last == 1) ? 0 : 1;
                else          pick = r0 ? 0 : 1;
                mo_owner = pick + 1;
                mo_last = pick;
                mo_wait = 0;
            end
        end
    end

    // Grant-order recorder for the round-robin scenario
    bit         rec_en = 1'b0;
    logic [1:0] rec_prev = 2'b00;
    logic [1:0] gord[$];
    always @(negedge clk) begin
        if (rec_en && bus.grant != 2'b00 && rec_prev == 2'b00) gord.push_back(bus.grant);
        rec_prev = bus.grant;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_lat(input int l);
        sl_lat = l;
        sl_wait = (l < 0) ? 0 : l;
    endtask

    // Issue one transaction at posedge+1 and hold it until done
    task automatic do_txn(input int x, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm, input bit to_exp);
        logic [32:0] e;
        int cyc;
        bit seen;
        if (wr) e = {1'b0, 32'h0};
        else    e = {1'b1, to_exp ? 32'hDEADBEEF : (sl_fix_en ? sl_fix : slv_data(a))};
        if (x == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        p_addr[x] = a; p_wdata[x] = wd; p_wmask[x] = wm;
        p_wen[x] = wr; p_ren[x] = !wr;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            seen = (x == 0) ? bus.m0_done : bus.m1_done;
            cyc++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL m%0d_done_wait: got no done in %0d cycles, expected one pulse", x, cyc);
        end
        @(posedge clk); #1;
        p_wen[x] = 1'b0; p_ren[x] = 1'b0;
    endtask

    task automatic rand_master(input int x, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            idle(int'($urandom_range(1, 3)));
            a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            do_txn(x, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int m1g, m0d;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p_wen[i] = 1'b0; p_ren[i] = 1'b0; p_addr[i] = 32'h0;
            p_wdata[i] = 32'h0; p_wmask[i] = 4'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", bus.grant, 32'h0);
        chk("rst_strobes", {bus.s_wen, bus.s_ren}, 32'h0);
        chk("rst_dones", {bus.m0_done, bus.m1_done}, 32'h0);
        chk("rst_err", bus.err, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic from both masters
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        idle(3);

        // Single master read, 1-cycle slave delay, fixed data
        set_lat(1);
        sl_fix_en = 1'b1;
        sl_fix = 32'h12345678;
        do_txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        sl_fix_en = 1'b0;
        set_lat(0);
        idle(2);

        // Both masters hammering: grants must alternate
        rec_en = 1'b1;
        fork
            begin repeat (3) begin do_txn(0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0); idle(1); end end
            begin repeat (3) begin do_txn(1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011, 1'b0); idle(1); end end
        join
        rec_en = 1'b0;
        chk("rr_grant_count", gord.size(), 32'd6);
        for (int i = 1; i < gord.size(); i++) chk("rr_alternate", gord[i], gord[i-1] ^ 2'b11);
        idle(2);

        // Reset while GRANT1 waits on a silent slave
        sl_mode = 1;
        p_addr[1] = 32'h200; p_wdata[1] = 32'h11223344; p_wmask[1] = 4'hF; p_wen[1] = 1'b1;
        idle(3);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {bus.s_wen, bus.s_ren}, 32'h0);
        chk("rst_mid_grant", bus.grant, 32'h0);
        chk("rst_mid_m1_done", bus.m1_done, 32'h0);
        p_wen[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sl_mode = 0;
        set_lat(0);
        idle(1);
        fork
            do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
            do_txn(1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0);
            begin @(negedge clk); @(negedge clk); chk("tie_after_rst", bus.grant, 32'h1); end
        join
        idle(2);

        // m1 abandons its read before the slave answers
        sl_mode = 1;
        p_addr[1] = 32'h500; p_ren[1] = 1'b1;
        idle(3);
        p_ren[1] = 1'b0;
        #1;
        chk("viol_strobe_drop", bus.s_ren, 32'h0);
        idle(2);
        chk("viol_back_idle", bus.grant, 32'h0);
        sl_mode = 0;
        set_lat(0);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Silent slave: timeout completes the read with the poison value
        sl_mode = 1;
        do_txn(0, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1);
        chk("err_set", bus.err, 32'h1);
        sl_mode = 0;
        set_lat(0);
        idle(1);
        do_txn(0, 1'b0, 32'h604, 32'h0, 4'h0, 1'b0);
        idle(1);
        chk("err_sticky", bus.err, 32'h1);
`else
        idle(1);
        chk("err_tied_low", bus.err, 32'h0);
`endif

        // Fixed priority: m1 never gets the bus while m0 keeps asking
        m1g = 0;
        m0d = 0;
        fp_on = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (fbus.grant == 2'b10) m1g++;
            if (fbus.m0_done) m0d++;
        end
        chk("fp_m1_granted", m1g, 32'd0);
        chk("fp_m0_dones", m0d, 32'd20);
        @(posedge clk); #1;
        fp_on = 1'b0;
        idle(3);

        chk("sb_q0_empty", exp_q0.size(), 32'd0);
        chk("sb_q1_empty", exp_q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
